// File: rtl/int_sched_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// int_sched_ctrl_pkg
//   Shared definitions for the interrupt scheduler: FSM state encodings,
//   default parameter values and a helper for the source-index width.
//   No ports (package).
// -----------------------------------------------------------------------------
package int_sched_ctrl_pkg;

    // Two-state handshake FSM
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_REQ  = 1'b1;

    // Default configuration
    localparam int          DEF_NSRC       = 4;
    localparam logic [31:0] DEF_VEC_BASE   = 32'h0000_0100;
    localparam logic [31:0] DEF_VEC_STRIDE = 32'h0000_0010;

    // Index width for n sources; a single source still needs a 1-bit index
    function automatic int id_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/int_prio_enc.sv
// -----------------------------------------------------------------------------
// int_prio_enc
//   Fixed-priority encoder, lowest set index wins.
//   Ports:
//     req_i   [N-1:0]   request vector
//     valid_o           any bit of req_i set
//     idx_o   [IDW-1:0] index of lowest set bit (0 when none)
// -----------------------------------------------------------------------------
module int_prio_enc #(
    parameter int N   = 4,
    parameter int IDW = 2
) (
    input  logic [N-1:0]   req_i,
    output logic           valid_o,
    output logic [IDW-1:0] idx_o
);

    always_comb begin
        valid_o = |req_i;
        idx_o   = '0;
        // Walk from the top down so the lowest set index is written last
        for (int i = N - 1; i >= 0; i--) begin
            if (req_i[i]) idx_o = IDW'(i);
        end
    end

endmodule

// File: rtl/int_sched_ctrl.sv
// -----------------------------------------------------------------------------
// int_sched_ctrl
//   Interrupt scheduler for the CP0 register block. Edge-detects external
//   requests, applies IE/INM enables, grants one source by fixed priority
//   (index 0 highest) and raises a break handshake. In-service levels nest
//   by priority and are retired by ERET.
//   Ports:
//     in_CLK, in_RST_N      clock, async active-low reset
//     in_IRQ   [NSRC-1:0]   raw requests (rising edge = new request)
//     in_IE                 global enable
//     in_INM   [NSRC-1:0]   per-source mask, 1 = masked
//     in_ACK                completes break handshake
//     in_ERET               ERET retiring, one-cycle pulse
//     out_BK                break request (registered)
//     out_NIE               IE value for CP0 to load (0 while out_BK)
//     out_ID   [IDW-1:0]    granted source index
//     out_VEC  [31:0]       handler address of out_ID
//     out_PEND [NSRC-1:0]   pending requests
//     out_ISR  [NSRC-1:0]   in-service bits
//     out_ERR               sticky: ERET with nothing in service
// -----------------------------------------------------------------------------
module int_sched_ctrl
    import int_sched_ctrl_pkg::*;
#(
    parameter int          NSRC       = DEF_NSRC,
    parameter logic [31:0] VEC_BASE   = DEF_VEC_BASE,
    parameter logic [31:0] VEC_STRIDE = DEF_VEC_STRIDE,
    localparam int         IDW        = id_w(NSRC)
) (
    input  logic            in_CLK,
    input  logic            in_RST_N,
    input  logic [NSRC-1:0] in_IRQ,
    input  logic            in_IE,
    input  logic [NSRC-1:0] in_INM,
    input  logic            in_ACK,
    input  logic            in_ERET,
    output logic            out_BK,
    output logic            out_NIE,
    output logic [IDW-1:0]  out_ID,
    output logic [31:0]     out_VEC,
    output logic [NSRC-1:0] out_PEND,
    output logic [NSRC-1:0] out_ISR,
    output logic            out_ERR
);

    logic [NSRC-1:0] irq_q;
    logic [NSRC-1:0] pend_q, pend_d;
    logic [NSRC-1:0] isr_q,  isr_d;
    logic [0:0]      state_q, state_d;
    logic [IDW-1:0]  id_q,   id_d;
    logic            err_q,  err_d;

    logic [NSRC-1:0] rise;
    logic [NSRC-1:0] above;
    logic [NSRC-1:0] elig;
    logic            elig_vld;
    logic [IDW-1:0]  elig_idx;
    logic            isr_vld;
    logic [IDW-1:0]  isr_lvl;
    logic            ack_hit;

    assign rise = in_IRQ & ~irq_q;

    // Current in-service level (lowest set isr index)
    int_prio_enc #(.N(NSRC), .IDW(IDW)) u_lvl_enc (
        .req_i   (isr_q),
        .valid_o (isr_vld),
        .idx_o   (isr_lvl)
    );

    // Only strictly higher priority than the active level may preempt
    always_comb begin
        above = '0;
        for (int i = 0; i < NSRC; i++) begin
            above[i] = ~isr_vld | (IDW'(i) < isr_lvl);
        end
    end

    assign elig = pend_q & ~in_INM & above;

    int_prio_enc #(.N(NSRC), .IDW(IDW)) u_grant_enc (
        .req_i   (elig),
        .valid_o (elig_vld),
        .idx_o   (elig_idx)
    );

    // ACK only counts while a break is outstanding
    assign ack_hit = (state_q == ST_REQ) && in_ACK;

    always_comb begin
        state_d = state_q;
        id_d    = id_q;
        case (state_q)
            ST_IDLE: begin
                if (in_IE && elig_vld) begin
                    state_d = ST_REQ;
                    id_d    = elig_idx;
                end
            end
            ST_REQ: begin
                // Request is committed; mask/IE changes cannot withdraw it
                if (in_ACK) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Clear of the granted source first, so a same-edge new request survives
    always_comb begin
        pend_d = pend_q;
        if (ack_hit) pend_d[id_q] = 1'b0;
        pend_d = pend_d | rise;
    end

    // ERET retires the old lowest level before ACK installs the new one
    always_comb begin
        isr_d = isr_q;
        err_d = err_q;
        if (in_ERET) begin
            if (isr_vld) isr_d = isr_q & (isr_q - NSRC'(1));
            else         err_d = 1'b1;
        end
        if (ack_hit) isr_d[id_q] = 1'b1;
    end

    always_ff @(posedge in_CLK or negedge in_RST_N) begin
        if (!in_RST_N) begin
            irq_q   <= '0;
            pend_q  <= '0;
            isr_q   <= '0;
            state_q <= ST_IDLE;
            id_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            irq_q   <= in_IRQ;
            pend_q  <= pend_d;
            isr_q   <= isr_d;
            state_q <= state_d;
            id_q    <= id_d;
            err_q   <= err_d;
        end
    end

    assign out_BK   = (state_q == ST_REQ);
    assign out_NIE  = ~out_BK;
    assign out_ID   = id_q;
    assign out_VEC  = VEC_BASE + (32'(id_q) * VEC_STRIDE);
    assign out_PEND = pend_q;
    assign out_ISR  = isr_q;
    assign out_ERR  = err_q;

endmodule

// File: tb/tb_int_sched_ctrl.sv
// -----------------------------------------------------------------------------
// tb_int_sched_ctrl
//   Directed bench for int_sched_ctrl with hand-computed expectations.
// -----------------------------------------------------------------------------
module tb_int_sched_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] irq, inm;
    logic       ie, ack, eret;
    logic       bk, nie, err;
    logic [1:0] id;
    logic [31:0] vec;
    logic [3:0] pend, isr;

    int vecs = 0;
    int errs = 0;

    int_sched_ctrl dut (
        .in_CLK   (clk),
        .in_RST_N (rst_n),
        .in_IRQ   (irq),
        .in_IE    (ie),
        .in_INM   (inm),
        .in_ACK   (ack),
        .in_ERET  (eret),
        .out_BK   (bk),
        .out_NIE  (nie),
        .out_ID   (id),
        .out_VEC  (vec),
        .out_PEND (pend),
        .out_ISR  (isr),
        .out_ERR  (err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n = 1'b0; irq = '0; inm = '0; ie = 1'b0; ack = 1'b0; eret = 1'b0;
        #2;
        chk("rst_bk",   32'(bk),   32'd0);
        chk("rst_nie",  32'(nie),  32'd1);
        chk("rst_id",   32'(id),   32'd0);
        chk("rst_vec",  vec,       32'h100);
        chk("rst_pend", 32'(pend), 32'd0);
        chk("rst_isr",  32'(isr),  32'd0);
        chk("rst_err",  32'(err),  32'd0);
        #1 rst_n = 1'b1;
        ie = 1'b1;

        // ACK while idle is ignored
        ack = 1'b1; tick();
        chk("idle_ack_isr", 32'(isr), 32'd0);
        chk("idle_ack_bk",  32'(bk),  32'd0);
        ack = 1'b0;

        // Basic grant of source 2
        irq = 4'b0100; tick();
        chk("t2_pend", 32'(pend), 32'b0100);
        chk("t2_bk0",  32'(bk),   32'd0);
        irq = 4'b0000; tick();
        chk("t2_bk",  32'(bk),  32'd1);
        chk("t2_id",  32'(id),  32'd2);
        chk("t2_vec", vec,      32'h120);
        chk("t2_nie", 32'(nie), 32'd0);
        ack = 1'b1; tick(); ack = 1'b0;
        chk("t2_isr",  32'(isr),  32'b0100);
        chk("t2_pnd0", 32'(pend), 32'd0);
        chk("t2_bkl",  32'(bk),   32'd0);
        chk("t2_nie1", 32'(nie),  32'd1);
        eret = 1'b1; tick(); eret = 1'b0;
        chk("t2_eret", 32'(isr), 32'd0);

        // Two simultaneous sources: 1 before 3
        irq = 4'b1010; tick(); irq = 4'b0000;
        chk("t3_pend", 32'(pend), 32'b1010);
        tick();
        chk("t3_id1", 32'(id), 32'd1);
        chk("t3_bk1", 32'(bk), 32'd1);
        ack = 1'b1; tick(); ack = 1'b0;
        chk("t3_isr", 32'(isr),  32'b0010);
        chk("t3_pnd", 32'(pend), 32'b1000);
        eret = 1'b1; tick(); eret = 1'b0;
        chk("t3_isr0", 32'(isr), 32'd0);
        chk("t3_bk0",  32'(bk),  32'd0);
        tick();
        chk("t3_bk3", 32'(bk), 32'd1);
        chk("t3_id3", 32'(id), 32'd3);
        chk("t3_vec", vec,     32'h130);
        ack = 1'b1; tick(); ack = 1'b0;
        chk("t3_isr3", 32'(isr), 32'b1000);
        eret = 1'b1; tick(); eret = 1'b0;

        // Nesting while source 2 in service
        irq = 4'b0100; tick(); irq = 4'b0000; tick();
        ack = 1'b1; tick(); ack = 1'b0;
        chk("t4_isr2", 32'(isr), 32'b0100);
        irq = 4'b1000; tick(); irq = 4'b0000;
        chk("t4_pnd3", 32'(pend), 32'b1000);
        tick();
        chk("t4_nobk_a", 32'(bk), 32'd0);
        tick();
        chk("t4_nobk_b", 32'(bk), 32'd0);
        irq = 4'b0001; tick(); irq = 4'b0000;
        chk("t4_pnd", 32'(pend), 32'b1001);
        tick();
        chk("t4_bk0", 32'(bk), 32'd1);
        chk("t4_id0", 32'(id), 32'd0);
        chk("t4_vec", vec,     32'h100);
        ack = 1'b1; tick(); ack = 1'b0;
        chk("t4_nest", 32'(isr),  32'b0101);
        chk("t4_pnd8", 32'(pend), 32'b1000);
        eret = 1'b1; tick(); eret = 1'b0;
        chk("t4_eret1", 32'(isr), 32'b0100);
        eret = 1'b1; tick(); eret = 1'b0;
        chk("t4_eret2", 32'(isr), 32'd0);
        tick();
        chk("t4_bk3", 32'(bk), 32'd1);
        chk("t4_id3", 32'(id), 32'd3);
        ack = 1'b1; tick(); ack = 1'b0;
        eret = 1'b1; tick(); eret = 1'b0;
        chk("t4_clean", 32'(isr), 32'd0);

        // Mask and IE gating; committed request is not retracted
        inm = 4'b0010;
        irq = 4'b0010; tick(); irq = 4'b0000;
        chk("t5_pend", 32'(pend), 32'b0010);
        tick();
        chk("t5_msk_a", 32'(bk), 32'd0);
        tick();
        chk("t5_msk_b", 32'(bk), 32'd0);
        inm = 4'b0000; tick();
        chk("t5_unmsk", 32'(bk), 32'd1);
        chk("t5_id1",   32'(id), 32'd1);
        inm = 4'b0010; ie = 1'b0; tick();
        chk("t5_hold_bk", 32'(bk), 32'd1);
        chk("t5_hold_id", 32'(id), 32'd1);
        ack = 1'b1; tick(); ack = 1'b0; inm = 4'b0000;
        chk("t5_isr", 32'(isr), 32'b0010);
        eret = 1'b1; tick(); eret = 1'b0;
        irq = 4'b0001; tick(); irq = 4'b0000; tick();
        chk("t5_ie0_a", 32'(bk), 32'd0);
        tick();
        chk("t5_ie0_b", 32'(bk), 32'd0);
        ie = 1'b1; tick();
        chk("t5_ie1_bk", 32'(bk), 32'd1);
        chk("t5_ie1_id", 32'(id), 32'd0);
        ack = 1'b1; tick(); ack = 1'b0;
        eret = 1'b1; tick(); eret = 1'b0;
        chk("t5_clean", 32'(isr), 32'd0);

        // ERET with nothing in service
        chk("t6_err0", 32'(err), 32'd0);
        eret = 1'b1; tick(); eret = 1'b0;
        chk("t6_err1", 32'(err), 32'd1);
        chk("t6_isr",  32'(isr), 32'd0);
        tick();
        chk("t6_sticky", 32'(err), 32'd1);
        // ERET on the same edge as ACK of ID 0 while ISR=0010
        irq = 4'b0010; tick(); irq = 4'b0000; tick();
        ack = 1'b1; tick(); ack = 1'b0;
        chk("t6_isr1", 32'(isr), 32'b0010);
        irq = 4'b0001; tick(); irq = 4'b0000; tick();
        chk("t6_id0", 32'(id), 32'd0);
        ack = 1'b1; eret = 1'b1; tick(); ack = 1'b0; eret = 1'b0;
        chk("t6_swap", 32'(isr), 32'b0001);
        chk("t6_err",  32'(err), 32'd1);
        eret = 1'b1; tick(); eret = 1'b0;

        // Level held high gives one request only
        irq = 4'b0100; tick();
        chk("lvl_pend", 32'(pend), 32'b0100);
        tick();
        chk("lvl_id", 32'(id), 32'd2);
        ack = 1'b1; tick(); ack = 1'b0;
        chk("lvl_pnd0", 32'(pend), 32'd0);
        tick();
        chk("lvl_pnd1", 32'(pend), 32'd0);
        irq = 4'b0000;
        eret = 1'b1; tick(); eret = 1'b0;

        // New edge on the same edge as ACK clearing it: set wins
        irq = 4'b1000; tick(); irq = 4'b0000; tick();
        chk("sw_id", 32'(id), 32'd3);
        irq = 4'b1000; ack = 1'b1; tick(); ack = 1'b0; irq = 4'b0000;
        chk("sw_pend", 32'(pend), 32'b1000);
        chk("sw_isr",  32'(isr),  32'b1000);
        eret = 1'b1; tick(); eret = 1'b0;
        tick();
        chk("sw_rebk", 32'(bk), 32'd1);

        // Async reset in the middle of a handshake
        #2 rst_n = 1'b0;
        #1;
        chk("ar_bk",   32'(bk),   32'd0);
        chk("ar_nie",  32'(nie),  32'd1);
        chk("ar_pend", 32'(pend), 32'd0);
        chk("ar_isr",  32'(isr),  32'd0);
        chk("ar_err",  32'(err),  32'd0);
        chk("ar_id",   32'(id),   32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
